// File: rtl/approx_mul_seq_pkg.sv
// approx_mul_seq_pkg: shared state encoding and digit/partial-product widths
package approx_mul_seq_pkg;
  localparam int DIGIT_W = 2;
  localparam int PP_W = 4;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
endpackage

// File: rtl/approx_mul_seq_x2.sv
// x2_approx_mul: 2b x 2b approximate multiplier (3x3 -> 13, 2x2 -> 12, rest exact)
module x2_approx_mul
  import approx_mul_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic [PP_W-1:0]    p
);
  always_comb p = (a == 2'd3 && b == 2'd3) ? 4'd13 :
                  (a == 2'd2 && b == 2'd2) ? 4'd12 : PP_W'(a) * PP_W'(b);
endmodule

// File: rtl/approx_mul_seq.sv
// approx_mul_seq: digit-serial approximate multiplier sharing one 2x2 datapath
module approx_mul_seq
  import approx_mul_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_res,
  output logic               out_ovf,
  output logic               busy
);
  localparam int DIGITS = WIDTH / 2;
  localparam int CW = $clog2(DIGITS);
  localparam int SW = $clog2(2 * WIDTH);
  localparam int AW = 2 * WIDTH;
  state_t state, nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic [CW-1:0] i, j;
  logic [AW-1:0] acc;
  logic ovf;
  logic [DIGIT_W-1:0] da, db;
  logic [PP_W-1:0] pp;
  logic [SW-1:0] sh;
  logic [AW:0] sum;
  logic j_end, last, accept;
  x2_approx_mul u_mul (.a(da), .b(db), .p(pp));
  always_comb begin
    da = DIGIT_W'(a_r >> {i, 1'b0});
    db = DIGIT_W'(b_r >> {j, 1'b0});
    sh = SW'({1'b0, i} + {1'b0, j}) << 1;
    sum = {1'b0, acc} + ((AW + 1)'(pp) << sh);
    j_end = j == CW'(DIGITS - 1);
    last = j_end && i == CW'(DIGITS - 1);
    accept = state == ST_IDLE && in_valid;
    in_ready = state == ST_IDLE;
    out_valid = state == ST_DONE;
    busy = state == ST_RUN || state == ST_DONE;
    out_res = acc;
    out_ovf = ovf;
    nxt = state == ST_IDLE ? (in_valid ? ST_RUN : ST_IDLE) :
          state == ST_RUN  ? (last ? ST_DONE : ST_RUN) :
          state == ST_DONE ? (out_ready ? ST_IDLE : ST_DONE) : ST_IDLE;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= ST_IDLE;
    else state <= nxt;
  // bit AW of the widened sum is the carry that left the accumulator
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      ovf <= 1'b0;
      i <= '0;
      j <= '0;
    end else if (accept) begin
      a_r <= in_a;
      b_r <= in_b;
      acc <= '0;
      ovf <= 1'b0;
      i <= '0;
      j <= '0;
    end else if (state == ST_RUN) begin
      acc <= sum[AW-1:0];
      ovf <= ovf | sum[AW];
      j <= j_end ? '0 : j + 1'b1;
      i <= j_end ? (last ? '0 : i + 1'b1) : i;
    end
endmodule

// File: tb/tb_approx_mul_seq.sv
// tb_approx_mul_seq: random and directed checks against a digit-sum reference model
module tb_approx_mul_seq;
  logic clk = 1'b0, resetn = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid, out_ovf, busy;
  logic [15:0] out_res;
  logic [15:0] exp_res = '0;
  logic exp_ovf = 1'b0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  approx_mul_seq #(.WIDTH(8)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_ovf(out_ovf), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int pp(input int x, input int y);
    if (x == 3 && y == 3) return 13;
    if (x == 2 && y == 2) return 12;
    return x * y;
  endfunction

  // exact sum of approximate partial products; overflow means it exceeded 16 bits
  function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b);
    longint t = 0;
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        t += longint'(pp(int'(a[2*x +: 2]), int'(b[2*y +: 2]))) << (2 * (x + y));
    return {t >= 65536, t[15:0]};
  endfunction

  always @(negedge clk)
    if (resetn) begin
      chk("busy_vs_ready", busy, !in_ready);
      if (out_valid) begin
        chk("out_res", out_res, exp_res);
        chk("out_ovf", out_ovf, exp_ovf);
      end
    end

  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_ready", in_ready, 1);
    {exp_ovf, exp_res} = model(a, b);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = 8'($urandom);
    in_b = 8'($urandom);
  endtask

  task automatic finish_op(input int hold, input bit pulse);
    int n = 1;
    while (!out_valid && n < 40) begin
      in_valid = pulse && n == 4;
      out_ready = pulse && n >= 2 && n <= 5;
      if (pulse) begin
        in_a = 8'($urandom);
        in_b = 8'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("latency_edges", n, 17);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_not_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_hs_ready", in_ready, 1);
    chk("post_hs_valid", out_valid, 0);
  endtask

  logic [7:0] dir_a [8] = '{8'h01, 8'h05, 8'h02, 8'hFF, 8'h03, 8'h02, 8'hFF, 8'h01};
  logic [7:0] dir_b [8] = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h03, 8'h02, 8'hFF, 8'h01};
  logic [16:0] dir_e [8] = '{17'h00001, 17'h00005, 17'h00002, 17'h00000,
                             17'h0000D, 17'h0000C, 17'h16EE5, 17'h00001};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_ovf", out_ovf, 0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      chk("model_literal", model(dir_a[k], dir_b[k]), dir_e[k]);
      start_op(dir_a[k], dir_b[k]);
      finish_op(1, 1'b0);
    end
    start_op(8'h9C, 8'h37);
    finish_op(20, 1'b1);
    start_op(8'hFF, 8'hFF);
    repeat (6) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_out_res", out_res, 0);
    chk("abort_out_ovf", out_ovf, 0);
    @(negedge clk) resetn = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      chk("abort_no_valid", out_valid, 0);
    end
    start_op(8'h05, 8'h01);
    finish_op(0, 1'b0);
    chk("after_abort_res", {exp_ovf, exp_res}, 17'h00005);
    for (int k = 0; k < 30; k++) begin
      start_op(8'($urandom), 8'($urandom));
      finish_op(int'($urandom_range(0, 3)), 1'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
